// File: rtl/impact_sram_sequencer.sv
// Precharge / wordline / sense sequencer for a banked SRAM macro.
// Commands and read data move through a shared serial port while idle.
module impact_sram_sequencer #(
   parameter int ROWS    = 32,
   parameter int BANKS   = 4,
   parameter int COLS    = 2,
   parameter int PRE_CYC = 2,
   parameter int WL_CYC  = 4
) (
   input  logic                  C,
   input  logic                  rst_n,
   input  logic                  SI,
   input  logic                  SE,
   input  logic                  GO,
   input  logic [COLS-1:0]       BL,
   input  logic [COLS-1:0]       BLb,
   output logic [BANKS-1:0]      PRE,
   output logic [BANKS*ROWS-1:0] WL,
   output logic                  SO,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);

   localparam int RW    = $clog2(ROWS);
   localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int CMD_W = BW + RW;
   localparam int MAXC  = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
   localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [RW:0] ROWS_L  = ROWS[RW:0];
   localparam logic [BW:0] BANKS_L = BANKS[BW:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRECH,
      S_WLON,
      S_FIN
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [CMD_W-1:0]        r_cmd;
   logic [COLS-1:0]         r_rd;
   logic                    r_err;
   logic [BW-1:0]           r_bank;
   logic [RW-1:0]           r_row;
   logic [CW-1:0]           r_cnt;

   logic [RW-1:0]           w_cmdRow;
   logic [BW-1:0]           w_cmdBank;
   logic                    w_inRange;
   logic                    w_cntLast;
   logic [BANKS-1:0]        w_pre;
   logic [BANKS*ROWS-1:0]   w_wl;

   assign w_cmdRow  = r_cmd[RW-1:0];
   assign w_cmdBank = r_cmd[CMD_W-1:RW];
   assign w_inRange = ({1'b0, w_cmdRow} < ROWS_L) && ({1'b0, w_cmdBank} < BANKS_L);
   assign w_cntLast = (r_state == S_PRECH) ? (r_cnt == CW'(PRE_CYC - 1))
                                           : (r_cnt == CW'(WL_CYC - 1));

   always_ff @(posedge C) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // PRE and WL are pure state decodes, so they can never overlap and at most one WL bit is set.
   always_comb begin
      w_next = r_state;
      w_pre  = '0;
      w_wl   = '0;
      case (r_state)
         S_IDLE:  if (GO) w_next = w_inRange ? S_PRECH : S_FIN;
         S_PRECH: if (w_cntLast) w_next = S_WLON;
         S_WLON:  if (w_cntLast) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      for (int b = 0; b < BANKS; b++) begin
         w_pre[b] = (r_state == S_PRECH) && (r_bank == BW'(b));
         for (int r = 0; r < ROWS; r++) begin
            w_wl[b*ROWS + r] = (r_state == S_WLON) && (r_bank == BW'(b)) && (r_row == RW'(r));
         end
      end
   end

   always_ff @(posedge C) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == S_IDLE || w_next != r_state) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // GO wins over SE in the same idle cycle, so an access always uses the pre-shift command.
   always_ff @(posedge C) begin
      if (!rst_n) begin
         r_cmd  <= '0;
         r_rd   <= '0;
         r_err  <= 1'b0;
         r_bank <= '0;
         r_row  <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            if (GO) begin
               if (w_inRange) begin
                  r_err  <= 1'b0;
                  r_bank <= w_cmdBank;
                  r_row  <= w_cmdRow;
               end else begin
                  r_err  <= 1'b1;
               end
            end else if (SE) begin
               r_cmd <= {r_cmd[CMD_W-2:0], SI};
               r_rd  <= r_rd << 1;
            end
         end
         if (r_state == S_WLON && w_cntLast) begin
            r_rd <= BL & ~BLb;
            if (|(BL ~^ BLb)) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign PRE  = w_pre;
   assign WL   = w_wl;
   assign SO   = r_rd[COLS-1];
   assign BUSY = (r_state != S_IDLE);
   assign DONE = (r_state == S_FIN);
   assign ERR  = r_err;

endmodule

// File: tb/tb_impact_sram_sequencer.sv
// Scoreboard bench for impact_sram_sequencer: a default instance plus a ROWS=20
// instance that shares the serial/bitline inputs but has its own GO.
module tb_impact_sram_sequencer;

   typedef struct {
      int   doneCycle;
      logic err;
      int   bank;
      int   wlIdx;
   } expRec_t;

   logic         C;
   logic         rst_n;
   logic         SI;
   logic         SE;
   logic         GO;
   logic         goB;
   logic [1:0]   BL;
   logic [1:0]   BLb;

   logic [3:0]   PRE;
   logic [127:0] WL;
   logic         SO;
   logic         BUSY;
   logic         DONE;
   logic         ERR;

   logic [3:0]   preB;
   logic [79:0]  wlB;
   logic         soB;
   logic         busyB;
   logic         doneB;
   logic         errB;

   int           cyc = 0;
   int           nCompared = 0;
   int           nMismatched = 0;
   int           idleFrom = 0;
   int           preCnt = 0;
   int           wlCnt = 0;
   int           badCnt = 0;
   int           badB = 0;
   logic [6:0]   expCmd = '0;
   logic [1:0]   expRd = '0;
   expRec_t      expQ[$];
   expRec_t      expQB[$];
   logic         soQ[$];

   impact_sram_sequencer dut (
      .C     (C),
      .rst_n (rst_n),
      .SI    (SI),
      .SE    (SE),
      .GO    (GO),
      .BL    (BL),
      .BLb   (BLb),
      .PRE   (PRE),
      .WL    (WL),
      .SO    (SO),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .ERR   (ERR)
   );

   impact_sram_sequencer #(.ROWS(20)) dutB (
      .C     (C),
      .rst_n (rst_n),
      .SI    (SI),
      .SE    (SE),
      .GO    (goB),
      .BL    (BL),
      .BLb   (BLb),
      .PRE   (preB),
      .WL    (wlB),
      .SO    (soB),
      .BUSY  (busyB),
      .DONE  (doneB),
      .ERR   (errB)
   );

   // Free-running clock and a cycle counter that both stimulus and monitor use as a timebase.
   initial C = 1'b0;
   always #5 C = ~C;

   always @(posedge C) cyc <= cyc + 1;

   function automatic void checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
      nCompared++;
      if (act !== expv) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   // Monitor: tallies PRE/WL activity against the head of the scoreboard, then on DONE
   // pops the record and checks latency, ERR and the exact number of PRE/WL cycles.
   // SO is checked whenever an idle shift consumes a bit.
   always @(negedge C) begin : monitor
      expRec_t e;
      if (!rst_n) begin
         preCnt = 0;
         wlCnt  = 0;
      end else begin
         if (PRE != '0) begin
            if (expQ.size() > 0 && PRE == (4'b0001 << expQ[0].bank)) preCnt++;
            else badCnt++;
         end
         if (WL != '0) begin
            if (expQ.size() > 0 && WL == (128'd1 << expQ[0].wlIdx)) wlCnt++;
            else badCnt++;
         end
         if (PRE != '0 && WL != '0) badCnt++;
         if (DONE) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedDone", 128'(1), 128'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput("doneCycle", 128'(cyc), 128'(e.doneCycle));
               checkOutput("errAtDone", 128'(ERR), 128'(e.err));
               checkOutput("preCycles", 128'(preCnt), 128'(2));
               checkOutput("wlCycles", 128'(wlCnt), 128'(4));
               checkOutput("badDrive", 128'(badCnt), 128'(0));
            end
            preCnt = 0;
            wlCnt  = 0;
         end
         if (SE && !GO && !BUSY) begin
            if (soQ.size() == 0) checkOutput("unexpectedShift", 128'(1), 128'(0));
            else checkOutput("soBit", 128'(SO), 128'(soQ.pop_front()));
         end
         if (preB != '0 || wlB != '0) badB++;
         if (doneB) begin
            if (expQB.size() == 0) begin
               checkOutput("unexpectedDoneB", 128'(1), 128'(0));
            end else begin
               e = expQB.pop_front();
               checkOutput("doneCycleB", 128'(cyc), 128'(e.doneCycle));
               checkOutput("errAtDoneB", 128'(errB), 128'(e.err));
            end
         end
      end
   end

   // Drives one cycle of inputs and, if the sequencer should accept them, pushes expectations.
   task automatic applyStimulus(input logic si, input logic se, input logic go, input logic gB);
      expRec_t e;
      int      bank;
      int      row;
      SI  = si;
      SE  = se;
      GO  = go;
      goB = gB;
      bank = int'(expCmd[6:5]);
      row  = int'(expCmd[4:0]);
      if (go && cyc >= idleFrom) begin
         e.doneCycle = cyc + 7;
         e.err       = |(BL ~^ BLb);
         e.bank      = bank;
         e.wlIdx     = bank * 32 + row;
         expQ.push_back(e);
         expRd    = BL & ~BLb;
         idleFrom = cyc + 8;
      end else if (gB && cyc >= idleFrom) begin
         e.doneCycle = cyc + 1;
         e.err       = 1'b1;
         e.bank      = bank;
         e.wlIdx     = 0;
         expQB.push_back(e);
         idleFrom = cyc + 2;
      end else if (se && cyc >= idleFrom) begin
         soQ.push_back(expRd[1]);
         expRd  = {expRd[0], 1'b0};
         expCmd = {expCmd[5:0], si};
      end
      @(posedge C);
      #1;
      SI  = 1'b0;
      SE  = 1'b0;
      GO  = 1'b0;
      goB = 1'b0;
   endtask

   task automatic shiftFrame(input logic [6:0] frame);
      for (int i = 6; i >= 0; i--) applyStimulus(frame[i], 1'b1, 1'b0, 1'b0);
   endtask

   task automatic waitIdle();
      while (cyc < idleFrom) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".PRE"},  128'(PRE),  128'(0));
      checkOutput({tag, ".WL"},   WL,         128'(0));
      checkOutput({tag, ".BUSY"}, 128'(BUSY), 128'(0));
      checkOutput({tag, ".DONE"}, 128'(DONE), 128'(0));
      checkOutput({tag, ".SO"},   128'(SO),   128'(0));
      checkOutput({tag, ".ERR"},  128'(ERR),  128'(0));
   endtask

   // Directed scenario list; expectations are queued by applyStimulus as each GO/shift is issued.
   initial begin
      rst_n = 1'b0;
      SI    = 1'b0;
      SE    = 1'b0;
      GO    = 1'b0;
      goB   = 1'b0;
      BL    = 2'b00;
      BLb   = 2'b00;
      repeat (2) @(posedge C);
      #1;
      rst_n = 1'b1;
      checkAllZero("reset");

      // Bank 2 row 5: PRE[2] for two cycles, WL[69] for four, clean sense gives rd=01.
      BL  = 2'b01;
      BLb = 2'b10;
      shiftFrame(7'b10_00101);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitIdle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      // Row 25 on the 20-row instance is out of range: ERR, no PRE/WL, DONE one cycle later.
      shiftFrame(7'b00_11001);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      waitIdle();
      checkOutput("errBSticky", 128'(errB), 128'(1));
      checkOutput("errAUntouched", 128'(ERR), 128'(0));

      // Equal bitline pair flags ERR, which stays set until the next good access clears it.
      BL  = 2'b11;
      BLb = 2'b11;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitIdle();
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("errSticky", 128'(ERR), 128'(1));
      BL  = 2'b01;
      BLb = 2'b10;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitIdle();

      // GO/SE pulsed while busy must be ignored; the follow-up GO proves cmd was not shifted.
      BL  = 2'b10;
      BLb = 2'b01;
      shiftFrame(7'b11_11111);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      waitIdle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitIdle();
      shiftFrame(7'b11_11111);

      // Reset in the fourth cycle of an access: outputs drop, no DONE, next access is normal.
      BL  = 2'b01;
      BLb = 2'b10;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      expQ.delete();
      expCmd   = '0;
      expRd    = '0;
      idleFrom = 0;
      @(posedge C);
      #1;
      rst_n = 1'b1;
      checkAllZero("midReset");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitIdle();

      // GO together with SE uses the pre-shift command; the repeat GO shows the shift was dropped.
      shiftFrame(7'b01_00011);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      waitIdle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitIdle();

      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pendingAccesses", 128'(expQ.size()), 128'(0));
      checkOutput("pendingAccessesB", 128'(expQB.size()), 128'(0));
      checkOutput("pendingShifts", 128'(soQ.size()), 128'(0));
      checkOutput("strayDrive", 128'(badCnt), 128'(0));
      checkOutput("strayDriveB", 128'(badB), 128'(0));
      checkOutput("idleBusyB", 128'(busyB), 128'(0));
      checkOutput("idleSoB", 128'(soB), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
